// File: rtl/d_reg_pipe_stage.sv
// One pipeline slice: a valid bit and a WIDTH-bit data register.
// Only rst loads RESET_VAL; flush clears the valid bit and leaves the data alone.
module d_reg_pipe_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] dat_in,
   output logic             vld,
   output logic [WIDTH-1:0] dat
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= 1'b0;
         dat <= RESET_VAL;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (load) begin
         vld <= vld_in;
         dat <= dat_in;
      end
   end

endmodule

// File: rtl/d_reg_pipe.sv
// DEPTH-stage retiming pipeline with valid/ready backpressure, bubble
// compression, synchronous flush and a registered occupancy count.
module d_reg_pipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0]            v_prev;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   logic [DEPTH-1:0][WIDTH-1:0] d_prev;
   logic                        acc;
   logic                        drn;

   // A stage can load when it is empty or everything downstream of it moves.
   always_comb begin
      rdy          = '0;
      rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--)
         rdy[i] = !v[i] | rdy[i+1];
   end

   assign in_ready  = rdy[0] & !flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign v_prev[i] = in_valid;
         assign d_prev[i] = in_data;
      end else begin : g_body
         assign v_prev[i] = v[i-1];
         assign d_prev[i] = d[i-1];
      end

      d_reg_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .load   (rdy[i]),
         .vld_in (v_prev[i]),
         .dat_in (d_prev[i]),
         .vld    (v[i]),
         .dat    (d[i])
      );
   end

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   // Tracks popcount(v) incrementally; a simultaneous accept and drain cancel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else if (acc && !drn)
         occupancy <= occupancy + 1'b1;
      else if (drn && !acc)
         occupancy <= occupancy - 1'b1;
   end

endmodule

// File: tb/tb_d_reg_pipe.sv
// Bench for d_reg_pipe: three instances (DEPTH 3, 1, 5) checked every cycle
// against a queue model of words in flight, plus directed scenarios.
module tb_d_reg_pipe;

   localparam int NDUT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fl  = 1'b0;
   logic       iv   [NDUT];
   logic       ordy [NDUT];
   logic       ir   [NDUT];
   logic       ov   [NDUT];
   logic [7:0] idat [NDUT];
   logic [7:0] odat [NDUT];
   logic [1:0] occ3;
   logic       occ1;
   logic [2:0] occ5;
   logic [31:0] occ_i [NDUT];

   int         dep [NDUT] = '{3, 1, 5};
   logic [7:0] rv  [NDUT] = '{8'hA5, 8'h3C, 8'h00};

   // model: words accepted but not yet drained, with the cycle they were accepted
   logic [7:0] mq_d [NDUT][$];
   int         mq_t [NDUT][$];
   int         t      = 0;
   int         n_tot  = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   d_reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_d3 (
      .clk(clk), .rst(rst), .flush(fl), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_data(odat[0]), .occupancy(occ3));

   d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_d1 (
      .clk(clk), .rst(rst), .flush(fl), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_data(odat[1]), .occupancy(occ1));

   d_reg_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u_d5 (
      .clk(clk), .rst(rst), .flush(fl), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_data(idat[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_data(odat[2]), .occupancy(occ5));

   assign occ_i[0] = 32'(occ3);
   assign occ_i[1] = 32'(occ1);
   assign occ_i[2] = 32'(occ5);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
   endtask

   // Called at a negedge with inputs applied; checks, updates model, advances one cycle.
   task automatic step();
      logic e_ir, e_ov;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         e_ir = !fl && (mq_d[k].size() < dep[k] || ordy[k]);
         // the oldest word is never blocked before the last stage
         e_ov = mq_d[k].size() > 0 && (t - mq_t[k][0] >= dep[k]);
         chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(e_ir));
         chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(e_ov));
         if (e_ov) chk($sformatf("out_data[%0d]", k), 32'(odat[k]), 32'(mq_d[k][0]));
         chk($sformatf("occupancy[%0d]", k), occ_i[k], 32'(mq_d[k].size()));
         if (fl) begin
            mq_d[k].delete();
            mq_t[k].delete();
         end else begin
            if (e_ov && ordy[k]) begin
               void'(mq_d[k].pop_front());
               void'(mq_t[k].pop_front());
            end
            if (iv[k] && e_ir) begin
               mq_d[k].push_back(idat[k]);
               mq_t[k].push_back(t);
            end
         end
      end
      t++;
      @(negedge clk);
   endtask

   // Reset pulse raised between edges; outputs must react with no clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_out_valid[%0d]", k), 32'(ov[k]), 32'd0);
         chk($sformatf("rst_out_data[%0d]", k), 32'(odat[k]), 32'(rv[k]));
         chk($sformatf("rst_occupancy[%0d]", k), occ_i[k], 32'd0);
         mq_d[k].delete();
         mq_t[k].delete();
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("rst_in_ready[%0d]", k), 32'(ir[k]), 32'd1);
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; idat[k] = 8'h00;
      end
      do_reset();

      // streaming 0x01..0x06 with no stalls
      for (int i = 1; i <= 6; i++) begin
         iv[0] = 1'b1; idat[0] = 8'(i);
         step();
      end
      iv[0] = 1'b0;
      repeat (4) step();

      // backpressure: fill, stall 0x13, release
      ordy[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[0] = 1'b1; idat[0] = 8'h10 + 8'(i);
         step();
      end
      idat[0] = 8'h13;
      #1;
      chk("bp_in_ready_full", 32'(ir[0]), 32'd0);
      chk("bp_occupancy_full", occ_i[0], 32'd3);
      step();
      ordy[0] = 1'b1;
      #1;
      chk("bp_in_ready_release", 32'(ir[0]), 32'd1);
      chk("bp_head_data", 32'(odat[0]), 32'h10);
      step();
      iv[0] = 1'b0;
      repeat (5) step();

      // flush a full pipe while offering a word
      ordy[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[0] = 1'b1; idat[0] = 8'h40 + 8'(i);
         step();
      end
      fl = 1'b1; idat[0] = 8'h77;
      #1;
      chk("flush_in_ready", 32'(ir[0]), 32'd0);
      step();
      fl = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
      #1;
      chk("flush_out_valid", 32'(ov[0]), 32'd0);
      chk("flush_occupancy", occ_i[0], 32'd0);
      repeat (4) step();

      // reset with two words in flight, then resume
      for (int i = 0; i < 2; i++) begin
         iv[0] = 1'b1; idat[0] = 8'h21 + 8'(i);
         step();
      end
      iv[0] = 1'b0;
      #1;
      chk("mid_occupancy_before_rst", occ_i[0], 32'd2);
      do_reset();
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         iv[0] = 1'b1; idat[0] = 8'h31 + 8'(i);
         step();
      end
      iv[0] = 1'b0;
      repeat (5) step();

      // random traffic on all three depths
      for (int n = 0; n < 10000; n++) begin
         for (int k = 0; k < NDUT; k++) begin
            iv[k]   = ($urandom_range(0, 3) != 0);
            ordy[k] = ($urandom_range(0, 2) != 0);
            idat[k] = 8'($urandom);
         end
         fl = ($urandom_range(0, 199) == 0);
         step();
      end
      fl = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1;
      end
      repeat (8) step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
